// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Optional jump support is enabled by defining IFU_JUMP_EN.
package ifu_pkg;

    localparam logic [6:0]  OPC_R    = 7'b0110011;
    localparam logic [6:0]  OPC_I    = 7'b0010011;
    localparam logic [6:0]  OPC_JAL  = 7'b1101111;
    localparam logic [6:0]  OPC_BR   = 7'b1100011;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic {
        StIdle,
        StWait
    } fetch_state_e;

endpackage

// File: rtl/if_ir_fetch_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and imem (slave).
interface if_ir_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );

endinterface

// File: rtl/ifu_ir_decode.sv
// Combinational IR field split, I-type immediate sign extension and opcode legality.
// IFU_JUMP_EN additionally treats JAL and branch opcodes as legal.
module ifu_ir_decode
    import ifu_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [6:0]  opcode_o,
    output logic [2:0]  funct3_o,
    output logic [6:0]  funct7_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [31:0] imm_o,
    output logic        illegal_op_o
);

    assign opcode_o = ir_i[6:0];
    assign funct3_o = ir_i[14:12];
    assign funct7_o = ir_i[31:25];
    assign rd_o     = ir_i[11:7];
    assign rs1_o    = ir_i[19:15];
    assign rs2_o    = ir_i[24:20];
    assign imm_o    = {{20{ir_i[31]}}, ir_i[31:20]};

    always_comb begin
        illegal_op_o = 1'b1;
        if (ir_i[6:0] == OPC_R || ir_i[6:0] == OPC_I) begin
            illegal_op_o = 1'b0;
        end
`ifdef IFU_JUMP_EN
        if (ir_i[6:0] == OPC_JAL || ir_i[6:0] == OPC_BR) begin
            illegal_op_o = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/if_ir_fetch.sv
// Instruction-fetch stage: PC, IR, imem req/ack FSM with timeout, and IR field decode.
// Define IFU_JUMP_EN to add pc_load/pc_target and accept JAL/branch opcodes.
module if_ir_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_Write,
    input  logic        IR_Write,
`ifdef IFU_JUMP_EN
    input  logic        pc_load,
    input  logic [31:0] pc_target,
`endif
    if_ir_fetch_if.master imem,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        fetch_busy,
    output logic        fetch_err,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm,
    output logic        illegal_op
);

    fetch_state_e state_q;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q;
    logic [31:0]  addr_q;
    logic         req_q;
    logic         valid_q;
    logic         busy_q;
    logic         err_q;
    logic [7:0]   cnt_q;

    always_comb begin
        pc_d = pc_q;
`ifdef IFU_JUMP_EN
        if (pc_load) begin
            pc_d = {pc_target[31:2], 2'b00};
        end else if (PC_Write) begin
            pc_d = pc_q + PC_STEP;
        end
`else
        if (PC_Write) begin
            pc_d = pc_q + PC_STEP;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Fetch FSM; every output it drives is registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ir_q    <= NOP_INSN;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (IR_Write) begin
                        addr_q  <= pc_q;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= 8'd0;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (imem.imem_ack) begin
                        ir_q    <= imem.imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (cnt_q == 8'(TIMEOUT_CYC)) begin
                        ir_q    <= NOP_INSN;
                        valid_q <= 1'b1;
                        err_q   <= 1'b1;
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign pc             = pc_q;
    assign ir             = ir_q;
    assign ir_valid       = valid_q;
    assign fetch_busy     = busy_q;
    assign fetch_err      = err_q;

    ifu_ir_decode u_decode (
        .ir_i        (ir_q),
        .opcode_o    (opcode),
        .funct3_o    (funct3),
        .funct7_o    (funct7),
        .rd_o        (rd),
        .rs1_o       (rs1),
        .rs2_o       (rs2),
        .imm_o       (imm),
        .illegal_op_o(illegal_op)
    );

endmodule
